// File: rtl/float2int_seq_if.sv
// Handshake bundle for the float2int_seq minifloat expander.
// master: the side that supplies minifloats and consumes integers.
// slave : the expander itself.
interface float2int_seq_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int INT_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] out_int;

    modport master (
        output in_valid, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_int
    );

    modport slave (
        input  in_valid, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_int
    );
endinterface

// File: rtl/float2int_seq.sv
// float2int_seq: expands a minifloat {e, m} back to an unsigned integer.
//   e == 0 : value = m
//   e  > 0 : value = {1, m} << (e - 1)
// Default build shifts one bit per cycle (IDLE -> SHIFT -> DONE).
// Build option FLOAT2INT_BARREL_EN replaces SHIFT with a single-cycle
// barrel shift on accept (IDLE -> DONE), leaving the handshake unchanged.
module float2int_seq #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int INT_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    float2int_seq_if.slave     bus,
    output logic               busy
);

    // The widest value, {1, all-ones m} << (2^EXP_W - 2), must fit in INT_W.
    generate
        if (INT_W < MAN_W + (1 << EXP_W) - 1) begin : g_width_check
            $error("float2int_seq: INT_W too narrow for EXP_W/MAN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [INT_W-1:0]   r_acc, w_acc_nxt;
    logic [EXP_W-1:0]   r_cnt, w_cnt_nxt;
    // Last value handed over on the output handshake; shown outside DONE.
    logic [INT_W-1:0]   r_last, w_last_nxt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_denorm;
    logic [EXP_W-1:0]   w_sh;
    logic [INT_W-1:0]   w_norm;
    logic [INT_W-1:0]   w_sub;

    // Decode of the incoming fields; only used on the accept edge.
    always_comb begin
        w_denorm = (bus.in_exp == '0);
        w_sh     = bus.in_exp - EXP_W'(1);
        w_norm   = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, bus.in_man};
        w_sub    = {{(INT_W-MAN_W){1'b0}}, bus.in_man};
    end

    // Flush suppresses accept even though in_ready stays high in IDLE.
    assign w_accept = bus.in_valid && w_in_ready && !flush;

    // Next-state and handshake outputs; flush overrides any handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && !flush) begin
`ifdef FLOAT2INT_BARREL_EN
                    w_acc_nxt   = w_denorm ? w_sub : (w_norm << w_sh);
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
`else
                    w_acc_nxt   = w_denorm ? w_sub : w_norm;
                    w_cnt_nxt   = w_denorm ? '0 : w_sh;
                    // e of 0 or 1 needs no shifting at all.
                    w_state_nxt = (w_denorm || w_sh == '0) ? DONE : SHIFT;
`endif
                end
            end
`ifndef FLOAT2INT_BARREL_EN
            SHIFT: begin
                w_acc_nxt = r_acc << 1;
                w_cnt_nxt = r_cnt - EXP_W'(1);
                if (r_cnt == EXP_W'(1))
                    w_state_nxt = DONE;
            end
`endif
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_last_nxt  = r_acc;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = r_acc;
            w_cnt_nxt   = r_cnt;
            w_last_nxt  = r_last;
        end
    end

    // State, datapath and delivered-value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_int   = (r_state == DONE) ? r_acc : r_last;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_float2int_seq.sv
// Directed bench for float2int_seq: reset, denormal, max value, back-to-back,
// backpressure, reset mid-conversion and flush. Expected values are
// hand-derived from value = (e==0) ? m : {1,m} << (e-1).
module tb_float2int_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   q[$];

    float2int_seq_if #(.EXP_W(3), .MAN_W(4), .INT_W(11)) bus ();

    float2int_seq #(.EXP_W(3), .MAN_W(4), .INT_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Record every completed output handshake.
    always @(posedge clk)
        if (rst_n && !flush && bus.out_valid && bus.out_ready)
            q.push_back(int'(bus.out_int));

    // Present one word for one edge; caller ensures the block is idle.
    task automatic accept(input logic [2:0] e, input logic [3:0] m);
        bus.in_valid = 1'b1;
        bus.in_exp   = e;
        bus.in_man   = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_exp   = ~e;
        bus.in_man   = ~m;
    endtask

    // Cycles from accept until out_valid is seen (1 = next cycle), bounded.
    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.out_int !== 11'd0) begin n_fail++; $display("FAIL reset_out_int got %0d exp 0", bus.out_int); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_denorm;
        int n;
        bus.out_ready = 1'b1;
        accept(3'd0, 4'd9);
        wait_valid(n);
        n_tests++; if (n !== 1) begin n_fail++; $display("FAIL denorm_latency got %0d exp 1", n); end
        n_tests++; if (bus.out_int !== 11'd9) begin n_fail++; $display("FAIL denorm_value got %0d exp 9", bus.out_int); end
        @(posedge clk); #1;
        n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL denorm_release got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
        n_tests++; if (bus.out_int !== 11'd9) begin n_fail++; $display("FAIL denorm_hold got %0d exp 9", bus.out_int); end
    endtask

    task automatic test_max;
        int n;
        int bad = 0;
        bus.out_ready = 1'b1;
        accept(3'd7, 4'd15);
        n = 1;
        while (!bus.out_valid && n < 50) begin
            if (busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            n++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL max_busy_window got %0d bad cycles exp 0", bad); end
        n_tests++; if (n !== 7) begin n_fail++; $display("FAIL max_latency got %0d exp 7", n); end
        n_tests++; if (bus.out_int !== 11'd1984) begin n_fail++; $display("FAIL max_value got %0d exp 1984", bus.out_int); end
        n_tests++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL max_done_flags got busy=%b rdy=%b exp 1/0", busy, bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL max_release got rdy=%b busy=%b exp 1/0", bus.in_ready, busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        q.delete();
        bus.out_ready = 1'b1;
        accept(3'd1, 4'd0);          // {1,0000} << 0 = 16
        @(posedge clk); #1;
        accept(3'd4, 4'd5);          // {1,0101} << 3 = 168
        wait_valid(n);
        n_tests++; if (n !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d exp 4", n); end
        @(posedge clk); #1;
        n_tests++; if (q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", q.size()); end
        else begin
            n_tests++; if (q[0] !== 16) begin n_fail++; $display("FAIL b2b_first got %0d exp 16", q[0]); end
            n_tests++; if (q[1] !== 168) begin n_fail++; $display("FAIL b2b_second got %0d exp 168", q[1]); end
        end
    endtask

    task automatic test_backpressure;
        int n;
        int bad = 0;
        bus.out_ready = 1'b0;
        accept(3'd5, 4'd3);          // {1,0011} << 4 = 304
        wait_valid(n);
        n_tests++; if (n !== 5) begin n_fail++; $display("FAIL bp_latency got %0d exp 5", n); end
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_int !== 11'd304) bad++;
            @(posedge clk); #1;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_int !== 11'd304) begin n_fail++; $display("FAIL bp_complete got vld=%b val=%0d exp 0/304", bus.out_valid, bus.out_int); end
    endtask

    task automatic test_reset_mid;
        int n;
        bus.out_ready = 1'b1;
        accept(3'd6, 4'd2);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got vld=%b rdy=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy); end
        n_tests++; if (bus.out_int !== 11'd0) begin n_fail++; $display("FAIL rstmid_out_int got %0d exp 0", bus.out_int); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        accept(3'd6, 4'd2);          // {1,0010} << 5 = 576
        wait_valid(n);
        n_tests++; if (n !== 6 || bus.out_int !== 11'd576) begin n_fail++; $display("FAIL rstmid_next got lat=%0d val=%0d exp 6/576", n, bus.out_int); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        int n;
        int bad = 0;
        q.delete();
        bus.out_ready = 1'b1;
        accept(3'd6, 4'd2);
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_abort got busy=%b rdy=%b vld=%b exp 0/1/0", busy, bus.in_ready, bus.out_valid); end
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL flush_no_result got %0d valid cycles exp 0", bad); end
        // flush with in_valid in IDLE must not accept the word
        bus.in_valid = 1'b1; bus.in_exp = 3'd3; bus.in_man = 4'd1; flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept got busy=%b exp 0", busy); end
        accept(3'd2, 4'd1);          // {1,0001} << 1 = 34
        wait_valid(n);
        n_tests++; if (n !== 2 || bus.out_int !== 11'd34) begin n_fail++; $display("FAIL flush_next got lat=%0d val=%0d exp 2/34", n, bus.out_int); end
        @(posedge clk); #1;
        n_tests++; if (q.size() !== 1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", q.size()); end
        else begin
            n_tests++; if (q[0] !== 34) begin n_fail++; $display("FAIL flush_delivered got %0d exp 34", q[0]); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_exp    = '0;
        bus.in_man    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_denorm();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
